// File: rtl/dmem_ctrl.sv
// dmem_ctrl: parametrised data-memory controller for the RV32I core.
// Handles byte/half/word loads and stores with sign or zero extension.
// A req/ack handshake adds WAIT_CYCLES wait states before each access.
// Out-of-range addresses and illegal funct3 codes are reported on err.
// Optional macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned accesses
// report err. When undefined, the misaligned low address bits are ignored.

module dmem_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    output logic              ack,
    output logic              err,
    output logic              busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t state, next_state;

    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic        we_q;
    logic [2:0]  funct3_q;

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              out_of_range;
    logic              illegal_op;
    logic              acc_err;
    logic [3:0]        byte_en;
    logic [31:0]       wdata;
    logic              write_en;
    logic [31:0]       rdata_word;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;

    assign ack      = (state == RESP);
    assign busy     = req & ~ack;
    assign dbg_data = mem[dbg_addr];

    // State register; reset returns the FSM to IDLE from any state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic for the handshake and wait-state sequencing.
    always_comb begin
        // NOTE: default assigned first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            WAIT:    if (cnt == 4'd1) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the request in IDLE and run the wait-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    addr_q   <= addr;
                    wd_q     <= wd;
                    we_q     <= we;
                    funct3_q <= funct3;
                    cnt      <= 4'(WAIT_CYCLES);
                end
                WAIT:    cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Decode the captured access: error conditions and store lanes.
    always_comb begin
        word_idx     = addr_q[ADDR_W+1:2];
        out_of_range = |addr_q[31:ADDR_W+2];
        case (funct3_q)
            3'b000, 3'b001, 3'b010: illegal_op = 1'b0;
            3'b100, 3'b101:         illegal_op = we_q;
            default:                illegal_op = 1'b1;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_err = out_of_range | illegal_op
                | ((funct3_q[1:0] == 2'b01) & addr_q[0])
                | ((funct3_q[1:0] == 2'b10) & (addr_q[1:0] != 2'b00));
`else
        acc_err = out_of_range | illegal_op;
`endif
        case (funct3_q[1:0])
            2'b00: begin
                byte_en = 4'b0001 << addr_q[1:0];
                wdata   = {4{wd_q[7:0]}};
            end
            2'b01: begin
                byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{wd_q[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wdata   = wd_q;
            end
        endcase
        write_en = (state == ACCESS) & we_q & ~acc_err & ~reset;
    end

    // Select and extend the load result from the addressed word.
    always_comb begin
        rdata_word = mem[word_idx];
        byte_sel   = rdata_word[{addr_q[1:0], 3'b000} +: 8];
        half_sel   = addr_q[1] ? rdata_word[31:16] : rdata_word[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = rdata_word;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase
    end

    // Register the load result and error at the ACCESS edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd  <= 32'd0;
            err <= 1'b0;
        end else if (state == ACCESS) begin
            err <= acc_err;
            rd  <= (acc_err | we_q) ? 32'd0 : load_data;
        end
    end

    // Commit stores to the enabled byte lanes.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto plain RAM; contents are undefined until written.
        if (write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl.
// Instance 0 uses WAIT_CYCLES=0 and instance 1 uses WAIT_CYCLES=3.
// Each instance is checked against a byte-array reference model.

module tb_dmem_ctrl;

    localparam int ADDR_W  = 5;
    localparam int NBYTES  = 4 * (2 ** ADDR_W);

    logic              clk = 1'b0;
    logic              reset    [2];
    logic              req      [2];
    logic              we       [2];
    logic [2:0]        funct3   [2];
    logic [31:0]       addr     [2];
    logic [31:0]       wd       [2];
    logic [31:0]       rd       [2];
    logic              ack      [2];
    logic              err      [2];
    logic              busy     [2];
    logic [ADDR_W-1:0] dbg_addr [2];
    logic [31:0]       dbg_data [2];

    logic [7:0] mb [2][NBYTES];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset[0]), .req(req[0]), .we(we[0]), .funct3(funct3[0]),
        .addr(addr[0]), .wd(wd[0]), .rd(rd[0]), .ack(ack[0]), .err(err[0]),
        .busy(busy[0]), .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0])
    );

    dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset[1]), .req(req[1]), .we(we[1]), .funct3(funct3[1]),
        .addr(addr[1]), .wd(wd[1]), .rd(rd[1]), .ack(ack[1]), .err(err[1]),
        .busy(busy[1]), .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: the memory is an array of bytes, and every access is a
    // naturally aligned run of 1, 2 or 4 bytes.
    function automatic void model(input int i, input logic w, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] r, output logic e);
        int  size;
        int  base;
        logic mis;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis  = (a % size) != 0;
        e    = (a >= NBYTES) || (f3 == 3) || (f3 == 6) || (f3 == 7) || (w && f3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        e = e || mis;
`else
        if (mis) e = e;
`endif
        r = 32'd0;
        if (!e) begin
            base = int'(a) - int'(a % size);
            for (int k = 0; k < size; k++) begin
                if (w) mb[i][base+k] = d[8*k +: 8];
                else   r[8*k +: 8]   = mb[i][base+k];
            end
            if (!w && !f3[2] && size < 4 && r[8*size-1]) begin
                for (int k = size; k < 4; k++) r[8*k +: 8] = 8'hFF;
            end
        end
    endfunction

    function automatic logic [31:0] model_word(input int i, input int idx);
        return {mb[i][4*idx+3], mb[i][4*idx+2], mb[i][4*idx+1], mb[i][4*idx]};
    endfunction

    task automatic access(input int i, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got_rd, output logic got_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        bit          acked;
        model(i, w, f3, a, d, exp_rd, exp_err);
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; funct3[i] = f3; addr[i] = a; wd[i] = d;
        lat = 0;
        acked = 1'b0;
        while (!acked && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ack[i]) acked = 1'b1;
            else        check("busy_wait", 32'(busy[i]), 32'd1);
        end
        got_rd  = rd[i];
        got_err = err[i];
        if (!acked) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), (i == 0) ? 32'd2 : 32'd5);
            check("busy_at_ack", 32'(busy[i]), 32'd0);
            check("rd", rd[i], exp_rd);
            check("err", 32'(err[i]), 32'(exp_err));
        end
        req[i] = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(ack[i]), 32'd0);
    endtask

    task automatic check_word(input int i, input int idx, input string tag);
        dbg_addr[i] = idx[ADDR_W-1:0];
        #1;
        check(tag, dbg_data[i], model_word(i, idx));
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic [2:0]  f3_tab [8];
        int          lat;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; funct3[i] = 3'd0;
            addr[i] = 32'd0; wd[i] = 32'd0; dbg_addr[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_ack", 32'(ack[i]), 32'd0);
            check("reset_err", 32'(err[i]), 32'd0);
            check("reset_rd", rd[i], 32'd0);
            check("reset_busy", 32'(busy[i]), 32'd0);
        end
        @(negedge clk);
        reset[0] = 1'b0; reset[1] = 1'b0;

        // Fill both memories so every word holds a known value.
        for (int i = 0; i < 2; i++)
            for (int idx = 0; idx < 2 ** ADDR_W; idx++)
                access(i, 1'b1, 3'd2, 32'(4 * idx), $urandom, r, e);

        // Directed sub-word sequence on the zero-wait instance.
        access(0, 1'b1, 3'd2, 32'h08, 32'hDEADBEEF, r, e);
        dbg_addr[0] = 5'd2; #1;
        check("dbg_sw", dbg_data[0], 32'hDEADBEEF);
        access(0, 1'b1, 3'd0, 32'h09, 32'h000000A5, r, e);
        dbg_addr[0] = 5'd2; #1;
        check("dbg_sb", dbg_data[0], 32'hDEADA5EF);
        access(0, 1'b0, 3'd0, 32'h09, 32'd0, r, e);
        check("lb", r, 32'hFFFFFFA5);
        access(0, 1'b0, 3'd4, 32'h09, 32'd0, r, e);
        check("lbu", r, 32'h000000A5);
        access(0, 1'b0, 3'd1, 32'h0A, 32'd0, r, e);
        check("lh", r, 32'hFFFFDEAD);
        access(0, 1'b0, 3'd5, 32'h0A, 32'd0, r, e);
        check("lhu", r, 32'h0000DEAD);
        access(0, 1'b0, 3'd2, 32'h08, 32'd0, r, e);
        check("lw", r, 32'hDEADA5EF);
        access(0, 1'b0, 3'd2, 32'h0A, 32'd0, r, e);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw_mis_rd", r, 32'd0);
        check("lw_mis_err", 32'(e), 32'd1);
`else
        check("lw_mis_rd", r, 32'hDEADA5EF);
        check("lw_mis_err", 32'(e), 32'd0);
`endif
        access(0, 1'b1, 3'd1, 32'h09, 32'h00001234, r, e);
        check_word(0, 2, "sh_mis_word");

        // Out-of-range store must leave every word untouched.
        access(0, 1'b1, 3'd2, 32'h80, 32'hCAFEF00D, r, e);
        check("oor_err", 32'(e), 32'd1);
        for (int idx = 0; idx < 2 ** ADDR_W; idx++) check_word(0, idx, "oor_word");
        access(0, 1'b0, 3'd3, 32'h04, 32'd0, r, e);
        check("f3_011_err", 32'(e), 32'd1);
        check("f3_011_rd", r, 32'd0);

        // Reset during a WAIT cycle aborts the store with no ack.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; funct3[1] = 3'd2; addr[1] = 32'h0C; wd[1] = 32'h12345678;
        repeat (2) begin @(posedge clk); #1; end
        reset[1] = 1'b1; req[1] = 1'b0;
        @(posedge clk); #1;
        reset[1] = 1'b0;
        check("abort_ack", 32'(ack[1]), 32'd0);
        check("abort_rd", rd[1], 32'd0);
        check("abort_err", 32'(err[1]), 32'd0);
        lat = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack[1]) lat++;
        end
        check("abort_no_ack", 32'(lat), 32'd0);
        check_word(1, 3, "abort_word3");
        access(1, 1'b0, 3'd2, 32'h0C, 32'd0, r, e);

        // Randomised mix on both instances.
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 2; i++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, NBYTES - 1)) : $urandom;
                access(i, 1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)], a, $urandom, r, e);
                if (n % 20 == 0) check_word(i, int'($urandom_range(0, 2 ** ADDR_W - 1)), "rand_word");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller for the RV32I core. It replaces the fixed 32-word, word-only, zero-latency data memory with four capabilities: configurable depth, RV32I sub-word loads and stores (byte/half/word, signed/unsigned), a configurable number of wait states behind a request/acknowledge handshake, and address-error reporting. It sits between the datapath's ALU result / store-data path and the register write-back mux. `busy` stalls the PC.

## Interface

Parameters
- `ADDR_W`, default 5: word-address bits; depth = 2**ADDR_W words of 32 bits.
- `WAIT_CYCLES`, default 0: extra cycles inserted before the access; legal range 0–15.

Ports (one clock; reset is synchronous and active-high)
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  access request; held by the requester until `ack`.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- `addr`  in  32  byte address (ALU result).
- `wd`  in  32  store data, unshifted rs2.
- `rd`  out  32  load result, extended; 0 on error or store.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `ack`: misaligned, out-of-range or illegal funct3.
- `busy`  out  1  combinational `req & ~ack`; PC-stall enable.
- `dbg_addr`  in  ADDR_W  debug word index.
- `dbg_data`  out  32  combinational read of `mem[dbg_addr]`.

## Operation

- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: on `req`=1 at an edge, capture `addr`, `we`, `funct3` and `wd`. If WAIT_CYCLES=0, go to ACCESS; otherwise load the counter with WAIT_CYCLES and go to WAIT.
- WAIT: decrement the counter each cycle; go to ACCESS on the edge where it reaches 1.
- ACCESS: one cycle. At its closing edge:
  - the store is committed to the enabled byte lanes, or the formatted load result is registered into `rd`;
  - `err` is registered;
  - the FSM goes to RESP.
- RESP: `ack`=1 for exactly one cycle, then IDLE. `req` is sampled only in IDLE, so a `req` still high on the cycle after RESP starts a new transaction.
- Word index is `addr[ADDR_W+1:2]`.
- Out of range: any bit of `addr[31:ADDR_W+2]` set → `err`, no write, `rd`=0.
- Illegal funct3 (011, 110, 111, and 100/101 with `we`=1) → `err`, no write.
- Store lanes:
  - sb writes byte `addr[1:0]` from `wd[7:0]`;
  - sh writes the half selected by `addr[1]` from `wd[15:0]`;
  - sw writes the full word.
- Loads: select the byte or half, then sign-extend (lb, lh) or zero-extend (lbu, lhu); lw returns the whole word.
- Misalignment: half access with `addr[0]`=1; word access with `addr[1:0]`≠0. Handling depends on the macro (see Configuration).
- The memory array is not cleared by reset; contents are undefined until written.

## Timing

- Reset values: state IDLE, counter 0, `ack` 0, `err` 0, `rd` 0.
- `busy` follows `req` (`req & ~ack`); `dbg_data` is combinational.
- Latency: `req` sampled at edge k → `ack` high during cycle k+WAIT_CYCLES+2.
- `rd` and `err` are valid during the `ack` cycle and hold until the next ACCESS edge.
- Reset mid-transaction: reset has priority at every edge. The FSM returns to IDLE, no write is committed (including at the ACCESS edge), and no `ack` is produced.
- No dbg-port bypass: a debug read in the same cycle as a store commit shows the old word; the new word is visible from the next cycle.

## Configuration

- `DMEM_MISALIGN_TRAP_EN` defined: a misaligned access gives `err`=1, no write and `rd`=0.
- Undefined: the misaligned low address bits are ignored and the access completes with `err`=0.
  - Half access uses half `addr[1]`.
  - Word access uses the aligned word.
- Out-of-range and illegal-funct3 detection are always present.

## Test plan

- WAIT_CYCLES=0; sw 0xDEADBEEF @0x08 → `ack` 2 cycles after `req`, `err`=0; `dbg_addr`=2 → 0xDEADBEEF.
- Then sb `wd`=0x000000A5 @0x09 → word 2 = 0xDEADA5EF; lb @0x09 → `rd`=0xFFFFFFA5; lbu @0x09 → 0x000000A5.
- lh @0x0A → 0xFFFFDEAD; lhu @0x0A → 0x0000DEAD; lw @0x08 → 0xDEADA5EF.
- lw @0x0A:
  - with macro → `err`=1, `rd`=0;
  - without macro → `err`=0, `rd`=0xDEADA5EF;
  - in both builds sh @0x09 is handled the same way (with macro: error and word unchanged).
- WAIT_CYCLES=3 → `ack` exactly 5 cycles after `req`, `busy` high for those 5 cycles. sw 0x12345678 @0x0C with reset asserted in a WAIT cycle → no `ack`; word 3 keeps its prior value.
- ADDR_W=5; sw @0x80 → `err`=1, no word changes. funct3=011 load → `err`=1, `rd`=0.
